// File: rtl/dtree_loader_pkg.sv
// Shared types and constants for the decision-tree feature loader.
// Contents: FSM state enum, selected feature indices, default widths.
// Imported by dtree_feature_select and dtree_feature_loader.
package dtree_loader_pkg;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_EVAL    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  // Feature indices consumed by the printed tree.
  localparam int IDX_X13  = 13;
  localparam int IDX_X27  = 27;
  localparam int IDX_X235 = 235;
  localparam int IDX_X264 = 264;
  localparam int IDX_X278 = 278;

  localparam int DEF_NUM_FEATURES = 279;
  localparam int DEF_FEAT_W       = 8;
  localparam int DEF_CLASS_W      = 5;

endpackage

// File: rtl/dtree_feature_select.sv
// Index comparator plus shadow register bank for the five tree features.
// Latency: shadow written on the edge that accepts the matching byte.
// Backpressure: none; writes only when the parent asserts wr.
// Ports: clk/rst, wr (byte accepted while collecting), idx (byte index),
//        data (byte), sh_x* (shadow values, copied to the tree bank by parent).
module dtree_feature_select
  import dtree_loader_pkg::*;
#(
  parameter int IDX_W  = 9,
  parameter int FEAT_W = DEF_FEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [FEAT_W-1:0] data,
  output logic [FEAT_W-1:0] sh_x13,
  output logic [FEAT_W-1:0] sh_x27,
  output logic [FEAT_W-1:0] sh_x235,
  output logic [FEAT_W-1:0] sh_x264,
  output logic [FEAT_W-1:0] sh_x278
);

  logic [4:0] we;

  always_comb begin
    we[0] = wr && (idx == IDX_W'(IDX_X13));
    we[1] = wr && (idx == IDX_W'(IDX_X27));
    we[2] = wr && (idx == IDX_W'(IDX_X235));
    we[3] = wr && (idx == IDX_W'(IDX_X264));
    we[4] = wr && (idx == IDX_W'(IDX_X278));
  end

  // No explicit discard on a bad record: a record only reaches the tree
  // after passing every index, so each shadow is rewritten before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_x13  <= '0;
      sh_x27  <= '0;
      sh_x235 <= '0;
      sh_x264 <= '0;
      sh_x278 <= '0;
    end else begin
      if (we[0]) sh_x13  <= data;
      if (we[1]) sh_x27  <= data;
      if (we[2]) sh_x235 <= data;
      if (we[3]) sh_x264 <= data;
      if (we[4]) sh_x278 <= data;
    end
  end

endmodule

// File: rtl/dtree_feature_loader.sv
// Serial record loader feeding the arrhythmia decision tree; returns its class.
// Latency: res_valid rises on the 3rd clk edge counting the one accepting the last byte.
// Backpressure: in_ready low from EVAL until the result handshake (res_valid & res_ready).
// Ports: in_data/in_valid/in_last/in_ready byte stream; feat_x* + feat_valid tree bank;
//        tree_class from tree; res_class/res_valid/res_ready result; frame_err bad-record pulse.
// Option: define DTREE_LOADER_CHECKSUM_EN to expect a trailing mod-256 checksum byte.
module dtree_feature_loader
  import dtree_loader_pkg::*;
#(
  parameter int NUM_FEATURES = DEF_NUM_FEATURES,
  parameter int FEAT_W       = DEF_FEAT_W,
  parameter int CLASS_W      = DEF_CLASS_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FEAT_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [FEAT_W-1:0]  feat_x13,
  output logic [FEAT_W-1:0]  feat_x27,
  output logic [FEAT_W-1:0]  feat_x235,
  output logic [FEAT_W-1:0]  feat_x264,
  output logic [FEAT_W-1:0]  feat_x278,
  output logic               feat_valid,
  input  logic [CLASS_W-1:0] tree_class,
  output logic [CLASS_W-1:0] res_class,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               frame_err
);

`ifdef DTREE_LOADER_CHECKSUM_EN
  localparam int NUM_BYTES = NUM_FEATURES + 1;
`else
  localparam int NUM_BYTES = NUM_FEATURES;
`endif
  localparam int               IDX_W    = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic              acc;
  logic              at_last;
  logic              sum_bad;
  logic [FEAT_W-1:0] sh_x13, sh_x27, sh_x235, sh_x264, sh_x278;

  assign acc     = in_valid && in_ready;
  assign at_last = (idx == LAST_IDX);

`ifdef DTREE_LOADER_CHECKSUM_EN
  logic [FEAT_W-1:0] csum;

  // Restarts on index 0, so no clearing is needed between records. At the
  // checksum slot the compare uses the value before this byte is folded in.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
    end else if (state == ST_COLLECT && acc) begin
      csum <= (idx == '0) ? in_data : csum + in_data;
    end
  end

  assign sum_bad = (in_data != csum);
`else
  assign sum_bad = 1'b0;
`endif

  dtree_feature_select #(
    .IDX_W  (IDX_W),
    .FEAT_W (FEAT_W)
  ) u_select (
    .clk     (clk),
    .rst     (rst),
    .wr      (state == ST_COLLECT && acc),
    .idx     (idx),
    .data    (in_data),
    .sh_x13  (sh_x13),
    .sh_x27  (sh_x27),
    .sh_x235 (sh_x235),
    .sh_x264 (sh_x264),
    .sh_x278 (sh_x278)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_COLLECT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: begin
        if (acc) begin
          if (in_last)      state_nxt = (at_last && !sum_bad) ? ST_EVAL : ST_COLLECT;
          else if (at_last) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN:   if (acc && in_last) state_nxt = ST_COLLECT;
      ST_EVAL:    state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_HOLD;
      ST_HOLD:    if (res_valid && res_ready) state_nxt = ST_COLLECT;
      default:    state_nxt = ST_COLLECT;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_COLLECT, ST_DRAIN: in_ready = 1'b1;
      default:              in_ready = 1'b0;
    endcase
  end

  // Index counter, visible feature bank, result register and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      feat_x13   <= '0;
      feat_x27   <= '0;
      feat_x235  <= '0;
      feat_x264  <= '0;
      feat_x278  <= '0;
      feat_valid <= 1'b0;
      res_class  <= '0;
      res_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      feat_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_COLLECT: begin
          if (acc) begin
            if (in_last) begin
              idx <= '0;
              if (!at_last || sum_bad) frame_err <= 1'b1;
            end else if (at_last) begin
              // Long record: idx stays saturated while DRAIN swallows the tail.
              frame_err <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: if (acc && in_last) idx <= '0;
        ST_EVAL: begin
          feat_x13   <= sh_x13;
          feat_x27   <= sh_x27;
          feat_x235  <= sh_x235;
          feat_x264  <= sh_x264;
          feat_x278  <= sh_x278;
          feat_valid <= 1'b1;
        end
        ST_CAPTURE: begin
          // feat_* have been stable for this whole cycle, so tree_class has settled.
          res_class <= tree_class;
          res_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            idx       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
